// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Owner encoding, observed state encoding, default widths.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int STARVE_W   = 4;
  localparam int BURST_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CPU   = 2'd1,
    ST_DBG   = 2'd2,
    ST_BURST = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arb_sat_counter.sv
// Saturating up-counter with clear and load-one.
// Priority: clr, then start (load 1), then inc.
module dmem_arb_sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         start,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // count register, sticks at MAX until cleared
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (start)
      q <= W'(1);
    else if (inc && (q != MAX_V))
      q <= q + W'(1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU / debug arbiter for the shared 256x16 data memory.
// Optional macro DMEM_ARB_STARVE_EN adds the debug starvation guarantee.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_burst,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        arb_state
);

  arb_state_t           state_q;
  arb_state_t           state_d;
  owner_t               owner;
  logic                 lock_q;
  logic                 lock_d;
  logic                 force_dbg;
  logic                 dbg_win;
  logic                 burst_go;
  logic                 burst_full;
  logic [BURST_W-1:0]   bcnt;
  logic [BURST_W-1:0]   bcnt_nxt;

`ifdef DMEM_ARB_STARVE_EN
  logic [STARVE_W-1:0]  scnt;
  logic                 hold_q;
  logic                 starve_clr;

  assign force_dbg  = dbg_req && (scnt == STARVE_W'(STARVE_LIMIT));
  assign starve_clr = ~dbg_req | dbg_gnt | hold_q;

  dmem_arb_sat_counter #(
    .W   (STARVE_W),
    .MAX (STARVE_LIMIT)
  ) u_starve (
    .clock (clock),
    .reset (reset),
    .clr   (starve_clr),
    .start (1'b0),
    .inc   (1'b1),
    .q     (scnt)
  );

  // one cycle of CPU-first after a burst runs out
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      hold_q <= 1'b0;
    else
      hold_q <= burst_go & burst_full;
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign force_dbg = 1'b0;
`endif

  assign dbg_win = ~reset & dbg_req
                 & (lock_q | force_dbg | ~cpu_req);

  assign burst_go   = dbg_gnt & dbg_burst;
  assign bcnt_nxt   = lock_q ? bcnt + BURST_W'(1)
                             : BURST_W'(1);
  assign burst_full = (bcnt_nxt == BURST_W'(BURST_MAX));

  dmem_arb_sat_counter #(
    .W   (BURST_W),
    .MAX (BURST_MAX)
  ) u_burst (
    .clock (clock),
    .reset (reset),
    .clr   (~burst_go),
    .start (~lock_q),
    .inc   (lock_q),
    .q     (bcnt)
  );

  // owner select, memory mux and next observed state
  always_comb begin
    owner     = OWN_NONE;
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    lock_d    = 1'b0;
    state_d   = ST_IDLE;
    if (dbg_win)
      owner = OWN_DBG;
    else if (~reset & cpu_req)
      owner = OWN_CPU;
    unique case (1'b1)
      owner == OWN_DBG: begin
        dbg_gnt   = 1'b1;
        mem_we    = dbg_we & dbg_req;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        state_d   = ST_DBG;
      end
      owner == OWN_CPU: begin
        cpu_gnt   = 1'b1;
        mem_we    = cpu_we & cpu_req;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        state_d   = ST_CPU;
      end
      default: ;
    endcase
    lock_d = burst_go & ~burst_full;
    if (lock_d)
      state_d = ST_BURST;
  end

  // state, lock and debug read capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lock_q     <= 1'b0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (dbg_gnt & ~dbg_we)
        dbg_rdata <= mem_rdata;
    end
  end

  assign cpu_stall = ~reset & cpu_req & ~cpu_gnt;
  assign cpu_rdata = mem_rdata;
  assign arb_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter.
// Reference model follows the grant/burst/starve rules directly.
module tb_dmem_arbiter;

  localparam int SL = 4;
  localparam int BM = 8;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_stall;
  logic [15:0] cpu_rdata;
  logic        dbg_req, dbg_we, dbg_burst;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  arb_state;

  dmem_arbiter #(
    .ADDR_W(8), .DATA_W(16),
    .STARVE_LIMIT(SL), .BURST_MAX(BM)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_burst(dbg_burst), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .arb_state(arb_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] init_val(int i);
    if (i == 32) return 16'hBEEF;
    return 16'(i * 37) ^ 16'h5a5a;
  endfunction

  // memory instance stand-in: async read, sync write
  logic [15:0] bmem [256];
  logic        preload;
  assign mem_rdata = bmem[mem_addr];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++)
        bmem[i] <= init_val(i);
    end else if (mem_we) begin
      bmem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    logic        cg, dg, stall, we;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic [1:0]  st;
    logic        rv;
    logic [15:0] rd;
    logic        chk_rd;
    logic [15:0] crd;
  } exp_t;

  exp_t        cq[$];
  logic [15:0] rq[$];
  int          errs = 0;
  int          checks = 0;

  int          m_wait, m_bcnt, m_st;
  bit          m_lock, m_hold, m_rv;
  logic [15:0] m_rd;
  logic [15:0] mmem [256];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step(
    input bit r,
    input bit creq, input bit cwe,
    input logic [7:0] ca, input logic [15:0] cwd,
    input bit dreq, input bit dwe, input bit db,
    input logic [7:0] da, input logic [15:0] dwd,
    output bit dg_o);
    exp_t e;
    bit   fo, dg, cg, fin;
    @(posedge clock);
    #1;
    reset = r;
    cpu_req = creq; cpu_we = cwe;
    cpu_addr = ca; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_burst = db;
    dbg_addr = da; dbg_wdata = dwd;
    e = '{default: '0};
    dg_o = 1'b0;
    if (r) begin
      m_wait = 0; m_bcnt = 0; m_st = 0;
      m_lock = 0; m_hold = 0; m_rv = 0; m_rd = '0;
      rq.delete();
      cq.push_back(e);
      return;
    end
    fo = STARVE && dreq && (m_wait >= SL);
    dg = (m_lock && dreq) || fo || (dreq && !creq);
    cg = creq && !dg;
    e.cg = cg;
    e.dg = dg;
    e.stall = creq && !cg;
    e.we = dg ? dwe : (cg ? cwe : 1'b0);
    e.addr = dg ? da : (cg ? ca : 8'h00);
    e.wd = dg ? dwd : (cg ? cwd : 16'h0);
    e.st = 2'(m_st);
    e.rv = m_rv;
    e.rd = m_rd;
    e.chk_rd = cg;
    e.crd = mmem[ca];
    cq.push_back(e);
    fin = 0;
    if (dg && db) begin
      m_bcnt = m_lock ? m_bcnt + 1 : 1;
      m_lock = (m_bcnt < BM);
      fin = !m_lock;
    end else begin
      m_lock = 0;
      m_bcnt = 0;
    end
    if (!dreq || dg || m_hold) m_wait = 0;
    else if (m_wait < SL) m_wait = m_wait + 1;
    m_hold = fin;
    if (dg && !dwe) begin
      m_rv = 1;
      m_rd = mmem[da];
      rq.push_back(mmem[da]);
    end else begin
      m_rv = 0;
    end
    if (e.we) mmem[e.addr] = e.wd;
    m_st = m_lock ? 3 : (dg ? 2 : (cg ? 1 : 0));
    dg_o = dg;
  endtask

  // monitor: per-cycle outputs and registered read returns
  exp_t me;
  initial begin
    forever begin
      @(negedge clock);
      if (cq.size() > 0) begin
        me = cq.pop_front();
        chk("cpu_gnt", 32'(cpu_gnt), 32'(me.cg));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(me.dg));
        chk("cpu_stall", 32'(cpu_stall), 32'(me.stall));
        chk("mem_we", 32'(mem_we), 32'(me.we));
        chk("mem_addr", 32'(mem_addr), 32'(me.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(me.wd));
        chk("arb_state", 32'(arb_state), 32'(me.st));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(me.rv));
        chk("dbg_rdata", 32'(dbg_rdata), 32'(me.rd));
        if (me.chk_rd)
          chk("cpu_rdata", 32'(cpu_rdata), 32'(me.crd));
      end
      if (dbg_rvalid === 1'b1) begin
        if (rq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL rvalid_extra got=1 want=0 t=%0t",
                   $time);
        end else begin
          chk("rd_return", 32'(dbg_rdata),
              32'(rq.pop_front()));
        end
      end
    end
  end

  initial begin
    bit          g, pend, dwe, db;
    logic [7:0]  da;
    logic [15:0] dwd;
    int          n, rate;
    for (int i = 0; i < 256; i++) mmem[i] = init_val(i);
    preload = 1'b1;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_burst = 0;
    dbg_addr = 0; dbg_wdata = 0;
    step(1, 0,0,8'h0,16'h0, 0,0,0,8'h0,16'h0, g);
    preload = 1'b0;
    step(1, 0,0,8'h0,16'h0, 0,0,0,8'h0,16'h0, g);

    step(0, 1,1,8'h10,16'h1234, 0,0,0,8'h0,16'h0, g);
    step(0, 0,0,8'h0,16'h0, 0,0,0,8'h0,16'h0, g);

    step(0, 0,0,8'h0,16'h0, 1,0,0,8'h20,16'h0, g);
    step(0, 0,0,8'h0,16'h0, 0,0,0,8'h0,16'h0, g);
    step(0, 0,0,8'h0,16'h0, 0,0,0,8'h0,16'h0, g);

    for (int i = 0; i < 8; i++)
      step(0, 1,0,8'h05,16'h0, 1,0,0,8'h21,16'h0, g);
    step(0, 0,0,8'h0,16'h0, 0,0,0,8'h0,16'h0, g);

    n = 0;
    for (int i = 0; i < 40 && n < 12; i++) begin
      step(0, 1,0,8'h06,16'h0, 1,1,1,
           8'(8'h40 + n), 16'(16'hD000 + n), g);
      if (g) n++;
    end
    for (int i = 0; i < 6; i++)
      step(0, 1,0,8'h41,16'h0, 0,0,0,8'h0,16'h0, g);

    for (int i = 0; i < 3; i++)
      step(0, 0,0,8'h0,16'h0, 1,0,1,8'(8'h40 + i),16'h0, g);
    step(1, 0,0,8'h0,16'h0, 1,0,1,8'h43,16'h0, g);
    step(1, 0,0,8'h0,16'h0, 1,0,1,8'h43,16'h0, g);
    step(0, 0,0,8'h0,16'h0, 0,0,0,8'h0,16'h0, g);
    step(0, 1,0,8'h44,16'h0, 0,0,0,8'h0,16'h0, g);

    pend = 0; dwe = 0; db = 0; da = 0; dwd = 0;
    rate = 30;
    for (int c = 0; c < 900; c++) begin
      if (c % 150 == 0) rate = (rate == 30) ? 85 : 30;
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        dwe = 1'($urandom);
        db = ($urandom_range(0, 3) == 0);
        da = 8'($urandom_range(0, 31));
        dwd = 16'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        step(1, 0,0,8'h0,16'h0, pend,dwe,db,da,dwd, g);
        pend = 0;
        continue;
      end
      step(0, ($urandom_range(0, 99) < rate),
           1'($urandom), 8'($urandom_range(0, 31)),
           16'($urandom),
           pend, dwe, db, da, dwd, g);
      if (g) begin
        if (db && $urandom_range(0, 7) != 0) begin
          da = da + 8'd1;
          dwd = 16'($urandom);
          dwe = 1'($urandom);
        end else begin
          pend = 0;
        end
      end
    end

    for (int i = 0; i < 3; i++)
      step(0, 0,0,8'h0,16'h0, 0,0,0,8'h0,16'h0, g);
    @(negedge clock);
    @(negedge clock);
    chk("cq_drained", 32'(cq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
